// File: rtl/hasti_arbiter_pkg.sv
// Shared HASTI encodings, widths and arbiter types used by the bus interfaces,
// the holding register and the two-master arbiter.
package hasti_arbiter_pkg;

    localparam int HASTI_ADDR_W  = 32;
    localparam int HASTI_DATA_W  = 32;
    localparam int HASTI_TRANS_W = 2;
    localparam int HASTI_SIZE_W  = 3;
    localparam int HASTI_BURST_W = 3;
    localparam int HASTI_PROT_W  = 4;
    localparam int HASTI_RESP_W  = 1;

    typedef enum logic [HASTI_TRANS_W-1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [HASTI_RESP_W-1:0] {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    typedef struct packed {
        logic [HASTI_ADDR_W-1:0]  haddr;
        logic                     hwrite;
        logic [HASTI_SIZE_W-1:0]  hsize;
        logic [HASTI_BURST_W-1:0] hburst;
        logic [HASTI_PROT_W-1:0]  hprot;
        logic [HASTI_TRANS_W-1:0] htrans;
        logic                     hmastlock;
    } addr_phase_t;

    function automatic owner_e idx_owner(input int idx);
        return (idx == 0) ? OWN_M0 : OWN_M1;
    endfunction

endpackage

// File: rtl/hasti_arbiter_if.sv
// HASTI master-side and slave-side bus bundles; "slave" modport of the master
// bundle and "master" modport of the slave bundle are the arbiter's views.
interface if_hasti_master_io;
    import hasti_arbiter_pkg::*;

    logic [HASTI_ADDR_W-1:0]  haddr;
    logic                     hwrite;
    logic [HASTI_SIZE_W-1:0]  hsize;
    logic [HASTI_BURST_W-1:0] hburst;
    logic [HASTI_PROT_W-1:0]  hprot;
    logic [HASTI_TRANS_W-1:0] htrans;
    logic                     hmastlock;
    logic [HASTI_DATA_W-1:0]  hwdata;
    logic [HASTI_DATA_W-1:0]  hrdata;
    logic                     hready;
    logic [HASTI_RESP_W-1:0]  hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        output hrdata, hready, hresp
    );
endinterface

interface if_hasti_slave_io;
    import hasti_arbiter_pkg::*;

    logic [HASTI_ADDR_W-1:0]  haddr;
    logic                     hwrite;
    logic [HASTI_SIZE_W-1:0]  hsize;
    logic [HASTI_BURST_W-1:0] hburst;
    logic [HASTI_PROT_W-1:0]  hprot;
    logic [HASTI_TRANS_W-1:0] htrans;
    logic                     hmastlock;
    logic [HASTI_DATA_W-1:0]  hwdata;
    logic [HASTI_DATA_W-1:0]  hrdata;
    logic                     hready;
    logic [HASTI_RESP_W-1:0]  hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/hasti_arb_hold.sv
// Holds one master's address phase that lost arbitration, until it is granted.
module hasti_arb_hold
    import hasti_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_capture,
    input  logic        i_clear,
    input  addr_phase_t i_phase,
    output logic        o_pend,
    output addr_phase_t o_phase
);

    logic        r_pend;
    addr_phase_t r_phase;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= 1'b0;
        end else if (i_capture) begin
            r_pend <= 1'b1;
        end else if (i_clear) begin
            r_pend <= 1'b0;
        end
    end

    // Payload is only meaningful while r_pend is set, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (i_capture) begin
            r_phase <= i_phase;
        end
    end

    assign o_pend  = r_pend;
    assign o_phase = r_phase;

endmodule

// File: rtl/hasti_arbiter.sv
// Two-master HASTI arbiter: fixed (m1 over m0) or round-robin grant onto one
// shared slave, with per-master holding registers, bus lock and ERROR forwarding.
module hasti_arbiter
    import hasti_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic             hclk,
    input  logic             reset,
    if_hasti_master_io.slave m0,
    if_hasti_master_io.slave m1,
    if_hasti_slave_io.master s
);

    owner_e      r_dp_owner;
    owner_e      w_dp_owner_nxt;
    owner_e      r_rr_last;
    owner_e      r_lock_owner;
    logic        r_lock;

    addr_phase_t w_live [2];
    addr_phase_t w_held [2];
    addr_phase_t w_src  [2];
    addr_phase_t w_sel;
    logic [1:0]  w_pend;
    logic [1:0]  w_live_req;
    logic [1:0]  w_req;
    logic [1:0]  w_elig;
    logic [1:0]  w_capture;
    logic [1:0]  w_clear;
    logic [1:0]  w_mhready;
    logic [1:0]  w_mhresp;
    owner_e      w_grant;
    logic        w_grant_acc;
    logic        w_err_first;

    assign w_live[0] = '{haddr: m0.haddr, hwrite: m0.hwrite, hsize: m0.hsize,
                         hburst: m0.hburst, hprot: m0.hprot, htrans: m0.htrans,
                         hmastlock: m0.hmastlock};
    assign w_live[1] = '{haddr: m1.haddr, hwrite: m1.hwrite, hsize: m1.hsize,
                         hburst: m1.hburst, hprot: m1.hprot, htrans: m1.htrans,
                         hmastlock: m1.hmastlock};

    hasti_arb_hold u_hold0 (
        .i_clk     (hclk),
        .i_rst     (reset),
        .i_capture (w_capture[0]),
        .i_clear   (w_clear[0]),
        .i_phase   (w_live[0]),
        .o_pend    (w_pend[0]),
        .o_phase   (w_held[0])
    );

    hasti_arb_hold u_hold1 (
        .i_clk     (hclk),
        .i_rst     (reset),
        .i_capture (w_capture[1]),
        .i_clear   (w_clear[1]),
        .i_phase   (w_live[1]),
        .o_pend    (w_pend[1]),
        .o_phase   (w_held[1])
    );

    // Request sources and eligibility; lock and first ERROR cycle mask requests.
    always_comb begin
        w_err_first = (s.hresp == HRESP_ERROR) && !s.hready;
        for (int i = 0; i < 2; i++) begin
            w_live_req[i] = w_live[i].htrans[1] && w_mhready[i];
            w_req[i]      = w_pend[i] || w_live_req[i];
            w_src[i]      = w_pend[i] ? w_held[i] : w_live[i];
            w_elig[i]     = w_req[i] && !reset
                            && !(r_lock && (r_lock_owner != idx_owner(i)))
                            && !(w_err_first && w_pend[i] && (r_dp_owner != idx_owner(i)));
        end
    end

    always_comb begin
        w_grant = OWN_NONE;
        if (w_elig[0] && w_elig[1]) begin
            if ((ROUND_ROBIN != 0) && (r_rr_last == OWN_M1)) begin
                w_grant = OWN_M0;
            end else begin
                w_grant = OWN_M1;
            end
        end else if (w_elig[1]) begin
            w_grant = OWN_M1;
        end else if (w_elig[0]) begin
            w_grant = OWN_M0;
        end
        w_grant_acc = s.hready && (w_grant != OWN_NONE);
        for (int i = 0; i < 2; i++) begin
            w_clear[i]   = w_grant_acc && (w_grant == idx_owner(i));
            w_capture[i] = w_live_req[i] && !reset && !w_clear[i];
        end
    end

    assign w_sel       = (w_grant == OWN_M1) ? w_src[1] : w_src[0];
    assign s.haddr     = w_sel.haddr;
    assign s.hwrite    = w_sel.hwrite;
    assign s.hsize     = w_sel.hsize;
    assign s.hburst    = w_sel.hburst;
    assign s.hprot     = w_sel.hprot;
    assign s.htrans    = (w_grant == OWN_NONE) ? HTRANS_IDLE : w_sel.htrans;
    assign s.hmastlock = (w_grant == OWN_NONE) ? 1'b0 : w_sel.hmastlock;

    // Data-phase owner: state register, next-state, and per-master outputs.
    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            r_dp_owner <= OWN_NONE;
        end else begin
            r_dp_owner <= w_dp_owner_nxt;
        end
    end

    always_comb begin
        w_dp_owner_nxt = r_dp_owner;
        if (s.hready) begin
            w_dp_owner_nxt = w_grant;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (r_dp_owner == idx_owner(i)) begin
                w_mhready[i] = s.hready;
                w_mhresp[i]  = s.hresp;
            end else begin
                w_mhready[i] = !w_pend[i];
                w_mhresp[i]  = HRESP_OKAY;
            end
        end
    end

    assign m0.hready = w_mhready[0];
    assign m1.hready = w_mhready[1];
    assign m0.hresp  = w_mhresp[0];
    assign m1.hresp  = w_mhresp[1];
    assign m0.hrdata = s.hrdata;
    assign m1.hrdata = s.hrdata;
    assign s.hwdata  = (r_dp_owner == OWN_M1) ? m1.hwdata : m0.hwdata;

    // Round-robin history and lock follow accepted grants only.
    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            r_rr_last    <= OWN_M0;
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_NONE;
        end else if (w_grant_acc) begin
            r_rr_last    <= w_grant;
            r_lock       <= w_sel.hmastlock;
            r_lock_owner <= w_grant;
        end
    end

endmodule

// File: doc/hasti_arbiter.md
HASTI_ARBITER -- requirements
Module: hasti_arbiter

Interface
REQ-001 Parameter: ROUND_ROBIN, default 0, meaning 0 = fixed priority m1 over m0, 1 = round-robin between m0 and m1.
REQ-002 hclk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0  if_hasti_master_io  interface  master 0 (imem side); arbiter drives hrdata, hready, hresp.
REQ-005 m1  if_hasti_master_io  interface  master 1 (dmem side); same direction as m0.
REQ-006 s  if_hasti_slave_io  interface  shared slave; arbiter drives all address-phase signals and hwdata.
REQ-007 Bus widths follow existing HASTI constants: haddr/hwdata/hrdata 32, htrans 2, hsize 3, hburst 3, hprot 4, hresp 1.

Function
REQ-008 Live request of master m: m.htrans is NONSEQ or SEQ while m.hready (arbiter output) is 1.
REQ-009 Per master, one holding register shall capture a complete address phase: haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock; pend_m flags it valid.
REQ-010 Request source for master m: holding register if pend_m=1, else the live address phase.
REQ-011 Each cycle the grant shall select one requesting source; with none, s.htrans = IDLE and other address signals are don't-care.
REQ-012 Fixed mode: m1 wins over m0. Round-robin mode: on contention, the master not granted last wins; pointer updates only on an accepted grant.
REQ-013 Grant shall be accepted when s.hready=1; next cycle dp_owner shall be the granted master and its pend flag shall clear.
REQ-014 A live request with m.hready=1 that is not accepted in that cycle shall be captured into m's holding register; pend_m=1 next cycle.
REQ-015 m.hready = s.hready when dp_owner=m; 0 when pend_m=1; otherwise 1.
REQ-016 s.hwdata = hwdata of dp_owner; m0 when dp_owner=NONE.
REQ-017 m.hrdata = s.hrdata for all masters; m.hresp = s.hresp when dp_owner=m, else OKAY.
REQ-018 dp_owner shall become NONE after any accepted IDLE cycle, or after a data phase that completes with no new grant.
REQ-019 Lock: after an accepted address phase from m with hmastlock=1, only m is eligible until m has an accepted phase with hmastlock=0; the other master's requests are captured and wait.
REQ-020 Pipelining: dp_owner m with s.hready=1 may be granted its next live address in the same cycle, giving zero-bubble back-to-back transfers.
REQ-021 ERROR response: both hresp cycles shall pass to dp_owner; during the first ERROR cycle, a pending request of the other master shall not be granted.
REQ-022 Latency: uncontended live request reaches the slave combinationally in the same cycle; a captured request costs at least one extra cycle.

Reset
REQ-023 While reset=1: pend_m=0, dp_owner=NONE, RR pointer=m0, lock cleared, s.htrans=IDLE, m0/m1 hready=1, m0/m1 hresp=OKAY.
REQ-024 Reset mid-transfer shall discard holding registers and any in-flight data phase without completing it.

Structure
REQ-025 Owner enum (NONE, M0, M1) and HTRANS/HRESP encodings shall live in the shared hasti package; the module shall not redefine them locally.
REQ-026 The holding register shall be one sub-module, hasti_arb_hold, instantiated once per master.

Verification
REQ-027 Solo m0 read of 0x00000100, s.hready=1 -> s.htrans=NONSEQ in the same cycle; m0.hrdata = slave data next cycle; no capture.
REQ-028 m0 and m1 NONSEQ in same cycle, ROUND_ROBIN=0 -> m1 granted; m0 captured with pend0=1 and m0.hready=0; m0 address reaches slave one cycle later.
REQ-029 ROUND_ROBIN=1, both masters requesting continuously for 6 cycles -> grants alternate m1,m0,m1,m0,... exactly.
REQ-030 m1 write to 0x40000020 data 0x000000A5, slave inserts 2 wait states -> m1.hready low 2 cycles, m0.hready stays 1, s.hwdata=0x000000A5 throughout.
REQ-031 m1 holds hmastlock=1 for 3 transfers while m0 requests -> m0 granted only after m1's unlocked transfer is accepted.
REQ-032 Assert reset while pend0=1 and dp_owner=M1 -> next cycle pend0=0, dp_owner=NONE, s.htrans=IDLE, both hready=1.
